// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT pointwise-multiply datapath.
package ntt_pkg;

    localparam int unsigned Q             = 8380417;   // 2^23 - 2^13 + 1
    localparam int unsigned N             = 256;
    localparam int unsigned W             = 23;
    localparam int unsigned BARRETT_M     = 33587228;  // floor(2^48 / Q)
    localparam int unsigned BARRETT_SHIFT = 48;

    // Counters need one extra bit so they can hold N itself.
    localparam int unsigned CNT_W = 9;

    typedef logic [W-1:0]     coeff_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        FILL,
        FLUSH,
        DRAIN
    } state_t;

endpackage

// File: rtl/mod_mul_q.sv
// Three-stage pipelined Barrett multiplier: c = a*b mod Q, one result per cycle.
module mod_mul_q
    import ntt_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_vld,
    input  coeff_t a,
    input  coeff_t b,
    output logic   out_vld,
    output coeff_t c
);

    localparam logic [71:0] MWide = 72'(BARRETT_M);
    localparam logic [71:0] QWide = 72'(Q);
    localparam logic [24:0] Q25   = 25'(Q);

    logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [45:0] p_q, p_d;
    logic [24:0] r_q, r_d;
    coeff_t      c_q, c_d;
    logic [71:0] p_wide;
    logic [24:0] sub_a, sub_b;

    // Next-state for all three stages.
    always_comb begin
        // s1: full 46-bit product
        v1_d   = in_vld;
        p_d    = {23'd0, a} * {23'd0, b};
        // s2: Barrett estimate; remainder is below 3Q so 25 bits suffice
        v2_d   = v1_q;
        p_wide = {26'd0, p_q};
        r_d    = 25'(p_wide - (((p_wide * MWide) >> BARRETT_SHIFT) * QWide));
        // s3: at most two corrective subtractions
        v3_d   = v2_q;
        sub_a  = (r_q >= Q25) ? (r_q - Q25) : r_q;
        sub_b  = (sub_a >= Q25) ? (sub_a - Q25) : sub_a;
        c_d    = coeff_t'(sub_b);
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            p_q  <= '0;
            r_q  <= '0;
            c_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            p_q  <= p_d;
            r_q  <= r_d;
            c_q  <= c_d;
        end
    end

    assign out_vld = v3_q;
    assign c       = c_q;

endmodule

// File: rtl/ntt_pointwise_mul.sv
// Pointwise multiply of a streamed NTT frame by a stored operand, buffered and
// drained under valid/ready.
module ntt_pointwise_mul
    import ntt_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic [7:0]   b_addr,
    input  logic [W-1:0] b_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    localparam cnt_t LastIdx = cnt_t'(N - 1);
    localparam cnt_t FullCnt = cnt_t'(N);

    state_t state_q, state_d;
    cnt_t   in_cnt_q, in_cnt_d;
    cnt_t   wr_cnt_q, wr_cnt_d;
    cnt_t   rd_cnt_q, rd_cnt_d;
    coeff_t out_data_q, out_data_d;
    logic   overflow_q, overflow_d;
    logic   sample;
    logic   mul_vld;
    coeff_t mul_c;
    coeff_t mem_q [N];

    mod_mul_q u_mod_mul_q (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (sample),
        .a       (in_data),
        .b       (b_data),
        .out_vld (mul_vld),
        .c       (mul_c)
    );

    // FSM next-state, counters and registered output word.
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        wr_cnt_d   = wr_cnt_q + cnt_t'(mul_vld);
        rd_cnt_d   = rd_cnt_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q | (in_valid && (state_q != FILL));
        sample     = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    sample   = 1'b1;
                    in_cnt_d = in_cnt_q + cnt_t'(1);
                    if (in_cnt_q == LastIdx) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Enter DRAIN on the same edge as the final buffer write.
                if (wr_cnt_d == FullCnt) begin
                    state_d    = DRAIN;
                    out_data_d = mem_q[0];
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_cnt_q == LastIdx) begin
                        done       = 1'b1;
                        state_d    = FILL;
                        in_cnt_d   = '0;
                        wr_cnt_d   = '0;
                        rd_cnt_d   = '0;
                        out_data_d = '0;
                    end else begin
                        rd_cnt_d   = rd_cnt_q + cnt_t'(1);
                        out_data_d = mem_q[rd_cnt_d[7:0]];
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Control state registers; rst overrides everything and drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            in_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Result buffer write port, fed straight from the multiplier.
    always_ff @(posedge clk) begin
        if (mul_vld) begin
            mem_q[wr_cnt_q[7:0]] <= mul_c;
        end
    end

    assign b_addr    = in_cnt_q[7:0];
    assign out_valid = (state_q == DRAIN);
    assign out_data  = out_data_q;
    assign busy      = (state_q != FILL);
    assign overflow  = overflow_q;

endmodule
